fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset; sampled on CLK rising edge.
REQ-004 IMEM_REQ  output  1  one-cycle instruction-fetch request pulse.
REQ-005 IMEM_ADDR  output  32  fetch address; equals PC.
REQ-006 IMEM_RVALID  input  1  response valid; arrives 1 or more cycles after IMEM_REQ.
REQ-007 IMEM_RDATA  input  32  instruction word, valid when IMEM_RVALID=1.
REQ-008 STALL_D  input  1  decode stage stalled; hold IF/ID register.
REQ-009 PCSRC_M  input  1  branch taken in memory stage; redirect and flush.
REQ-010 PCBRANCH_M  input  32  branch target, valid when PCSRC_M=1.
REQ-011 INSTR_D  output  32  IF/ID instruction.
REQ-012 OPCODE_D  output  6  INSTR_D[31:26], feeds the controller opcode input.
REQ-013 FUNCT_D  output  6  INSTR_D[5:0], feeds the controller funct input.
REQ-014 PCPLUS4_D  output  32  IF/ID PC+4.
REQ-015 VALID_D  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-016 FSM states: ISSUE, WAIT, HOLD, DRAIN; at most one request outstanding.
REQ-017 ISSUE: IMEM_REQ = !PCSRC_M; if the request is issued -> WAIT, else stay ISSUE.
REQ-018 WAIT, IMEM_RVALID=1, STALL_D=0: IF/ID <= {IMEM_RDATA, PC+4, valid}; PC <= PC+4; -> ISSUE.
REQ-019 WAIT, IMEM_RVALID=1, STALL_D=1: IMEM_RDATA into 1-entry buffer; PC unchanged; -> HOLD.
REQ-020 HOLD, STALL_D=0: IF/ID <= buffer; PC <= PC+4; -> ISSUE. HOLD, STALL_D=1: no change.
REQ-021 STALL_D=1 with no redirect: INSTR_D, PCPLUS4_D, VALID_D hold their values.
REQ-022 PCSRC_M=1 in any state: PC <= {PCBRANCH_M[31:2],2'b00}; VALID_D <= 0; INSTR_D <= 0; buffer discarded.
REQ-023 PCSRC_M=1 in WAIT without IMEM_RVALID -> DRAIN; with IMEM_RVALID (response discarded), HOLD or ISSUE -> ISSUE.
REQ-024 DRAIN: the next IMEM_RVALID is discarded -> ISSUE; PCSRC_M=1 in DRAIN updates PC and stays in DRAIN.
REQ-025 Priority: RESET > PCSRC_M > STALL_D > normal advance; a flush overrides a stall.
REQ-026 IMEM_RVALID in ISSUE or HOLD is ignored.
REQ-027 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 IMEM_ADDR = PC combinationally; minimum latency REQ to VALID_D = 2 edges when memory latency is 1.

Reset
REQ-029 RESET=0 at an edge: PC=RESET_PC, state=ISSUE, buffer empty, INSTR_D=0, PCPLUS4_D=0, VALID_D=0.
REQ-030 IMEM_REQ=0 while RESET=0; first request is issued in the first cycle after release.
REQ-031 Reset mid-WAIT abandons the request; instruction memory shares RESET, and stale responses after reset fall outside the contract.

Structure
REQ-032 Shared package fetch_pkg holds: state enum, NOP_INSTR (32'h0), RESET_PC default.
REQ-033 IF/ID storage uses one sub-module, flopenrc (parameterised width, enable, synchronous clear); this is the only sub-module.

Verification
REQ-034 Reset release, 1-cycle memory returning 32'h2002_0005 -> IMEM_ADDR=0, INSTR_D=32'h2002_0005, PCPLUS4_D=4, VALID_D=1 two edges after release.
REQ-035 STALL_D=1 for 3 cycles while a response arrives -> IF/ID frozen, state HOLD; one edge after STALL_D drops, the buffered word appears and PC advances by 4.
REQ-036 PCSRC_M=1, PCBRANCH_M=32'h40 in WAIT, response 2 cycles later -> response discarded, VALID_D=0, next IMEM_ADDR=32'h40.
REQ-037 PCSRC_M=1 and STALL_D=1 in the same cycle -> VALID_D=0, INSTR_D=0, PC=target.
REQ-038 RESET_PC=32'hFFFF_FFFC, one fetch -> PCPLUS4_D=0, next IMEM_ADDR=0.
REQ-039 Reset asserted mid-HOLD -> all outputs at their reset values, buffer empty, IMEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The IF/ID word is packed as {instr[31:0], pc_plus4[31:0], valid}.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          IFID_W           = 65;

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Enable flop with synchronous active-low reset and synchronous clear.
// Clear has priority over enable so a flush always wins over a hold.
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, one-word skid
// buffer for stalled responses, and the IF/ID pipeline register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL_D,
  input  logic        PCSRC_M,
  input  logic [31:0] PCBRANCH_M,
  output logic [31:0] INSTR_D,
  output logic [5:0]  OPCODE_D,
  output logic [5:0]  FUNCT_D,
  output logic [31:0] PCPLUS4_D,
  output logic        VALID_D,
  output logic [1:0]  DBG_STATE
);

  fetch_state_e        state_q;
  logic [31:0]         pc_q;
  logic [31:0]         buf_q;
  logic [31:0]         pc_plus4;
  logic                capture;
  logic [IFID_W-1:0]   ifid_d;
  logic [IFID_W-1:0]   ifid_q;

  assign pc_plus4  = pc_q + 32'd4;
  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = RESET && (state_q == ST_ISSUE) && !PCSRC_M;
  assign DBG_STATE = state_q;

  // IF/ID takes a new word only when decode advances; when decode advances
  // without a new word a bubble is loaded so no instruction is seen twice.
  always_comb begin
    capture = 1'b0;
    ifid_d  = {NOP_INSTR, 32'h0, 1'b0};
    if (!PCSRC_M && !STALL_D) begin
      if (state_q == ST_WAIT && IMEM_RVALID) begin
        capture = 1'b1;
        ifid_d  = {IMEM_RDATA, pc_plus4, 1'b1};
      end else if (state_q == ST_HOLD) begin
        capture = 1'b1;
        ifid_d  = {buf_q, pc_plus4, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else if (PCSRC_M) begin
      pc_q  <= {PCBRANCH_M[31:2], 2'b00};
      buf_q <= NOP_INSTR;
      // A request still in flight must have its response swallowed.
      if (state_q == ST_DRAIN || (state_q == ST_WAIT && !IMEM_RVALID)) begin
        state_q <= ST_DRAIN;
      end else begin
        state_q <= ST_ISSUE;
      end
    end else begin
      case (state_q)
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (IMEM_RVALID) begin
            if (STALL_D) begin
              buf_q   <= IMEM_RDATA;
              state_q <= ST_HOLD;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_HOLD: begin
          if (!STALL_D) begin
            pc_q    <= pc_plus4;
            buf_q   <= NOP_INSTR;
            state_q <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (IMEM_RVALID) begin
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_ISSUE;
      endcase
    end
  end

  flopenrc #(.WIDTH(IFID_W)) u_ifid (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .en_i   (!STALL_D),
    .clr_i  (PCSRC_M),
    .d_i    (ifid_d),
    .q_o    (ifid_q)
  );

  assign INSTR_D   = ifid_q[64:33];
  assign PCPLUS4_D = ifid_q[32:1];
  assign VALID_D   = ifid_q[0];
  assign OPCODE_D  = INSTR_D[31:26];
  assign FUNCT_D   = INSTR_D[5:0];

  logic unused_capture;
  assign unused_capture = capture;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model, directed stimulus with a consume-side
// scoreboard on IF/ID, plus a second instance exercising PC wrap-around.
module tb_fetch_stage;
  import fetch_pkg::*;

  // clock / reset
  logic CLK;
  logic RESET, RESET2;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // dut 1 (RESET_PC = 0)
  logic        IMEM_REQ, IMEM_RVALID, STALL_D, PCSRC_M, VALID_D;
  logic [31:0] IMEM_ADDR, IMEM_RDATA, PCBRANCH_M, INSTR_D, PCPLUS4_D;
  logic [5:0]  OPCODE_D, FUNCT_D;
  logic [1:0]  DBG_STATE;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .STALL_D(STALL_D),
    .PCSRC_M(PCSRC_M), .PCBRANCH_M(PCBRANCH_M), .INSTR_D(INSTR_D),
    .OPCODE_D(OPCODE_D), .FUNCT_D(FUNCT_D), .PCPLUS4_D(PCPLUS4_D),
    .VALID_D(VALID_D), .DBG_STATE(DBG_STATE)
  );

  // dut 2 (RESET_PC at the top of the address space)
  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, instr2, pcp4_2;
  logic [5:0]  op2, fn2;
  logic [1:0]  st2;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RESET(RESET2), .IMEM_REQ(req2), .IMEM_ADDR(addr2),
    .IMEM_RVALID(rvalid2), .IMEM_RDATA(rdata2), .STALL_D(1'b0),
    .PCSRC_M(1'b0), .PCBRANCH_M(32'h0), .INSTR_D(instr2),
    .OPCODE_D(op2), .FUNCT_D(fn2), .PCPLUS4_D(pcp4_2),
    .VALID_D(valid2), .DBG_STATE(st2)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // memory model: responds mem_lat cycles after an accepted request
  int          mem_lat = 1;
  logic        req_seen = 1'b0, rst_seen = 1'b0, pend = 1'b0;
  logic [31:0] addr_seen = '0, pend_addr = '0;
  int          cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : {16'hC0DE, a[15:0]};
  endfunction

  always @(negedge CLK) begin
    req_seen  = IMEM_REQ;
    addr_seen = IMEM_ADDR;
    rst_seen  = RESET;
  end

  always @(posedge CLK) begin
    #1;
    IMEM_RVALID = 1'b0;
    if (!rst_seen) begin
      pend = 1'b0;
    end else begin
      if (req_seen) begin
        pend      = 1'b1;
        cnt       = mem_lat;
        pend_addr = addr_seen;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          IMEM_RVALID = 1'b1;
          IMEM_RDATA  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor: an IF/ID word is consumed at an edge where decode
  // advances and no flush squashes it
  always @(negedge CLK) begin
    if (RESET === 1'b1 && VALID_D === 1'b1 && STALL_D === 1'b0 && PCSRC_M === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifid_consume: got %h expected none", {INSTR_D, PCPLUS4_D});
      end else begin
        check("ifid_consume", {INSTR_D, PCPLUS4_D}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0; RESET2 = 1'b0;
    STALL_D = 1'b0; PCSRC_M = 1'b0; PCBRANCH_M = '0;
    IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    rvalid2 = 1'b0; rdata2 = '0;
    repeat (3) step();

    // reset values
    check("rst_valid", 64'(VALID_D), 64'd0);
    check("rst_instr", 64'(INSTR_D), 64'd0);
    check("rst_pcp4",  64'(PCPLUS4_D), 64'd0);
    check("rst_req",   64'(IMEM_REQ), 64'd0);
    check("rst_addr",  64'(IMEM_ADDR), 64'd0);
    check("rst_state", 64'(DBG_STATE), 64'(ST_ISSUE));

    // first fetch, then a 3-cycle stall over a response
    exp_q.push_back({32'h2002_0005, 32'h0000_0004});
    exp_q.push_back({32'hC0DE_0004, 32'h0000_0008});
    exp_q.push_back({32'hC0DE_0008, 32'h0000_000C});
    RESET = 1'b1;
    #1;
    check("c0_req",  64'(IMEM_REQ), 64'd1);
    check("c0_addr", 64'(IMEM_ADDR), 64'd0);
    step();
    check("c1_state", 64'(DBG_STATE), 64'(ST_WAIT));
    step();
    check("c2_instr",  64'(INSTR_D), 64'h2002_0005);
    check("c2_pcp4",   64'(PCPLUS4_D), 64'd4);
    check("c2_valid",  64'(VALID_D), 64'd1);
    check("c2_opcode", 64'(OPCODE_D), 64'h08);
    check("c2_funct",  64'(FUNCT_D), 64'h05);
    STALL_D = 1'b1;
    step();
    check("c3_state", 64'(DBG_STATE), 64'(ST_WAIT));
    check("c3_instr", 64'(INSTR_D), 64'h2002_0005);
    step();
    check("c4_state", 64'(DBG_STATE), 64'(ST_HOLD));
    check("c4_instr", 64'(INSTR_D), 64'h2002_0005);
    check("c4_valid", 64'(VALID_D), 64'd1);
    step();
    check("c5_state", 64'(DBG_STATE), 64'(ST_HOLD));
    check("c5_req",   64'(IMEM_REQ), 64'd0);
    check("c5_addr",  64'(IMEM_ADDR), 64'd4);
    STALL_D = 1'b0;
    step();
    check("c6_instr", 64'(INSTR_D), 64'hC0DE_0004);
    check("c6_pcp4",  64'(PCPLUS4_D), 64'd8);
    check("c6_addr",  64'(IMEM_ADDR), 64'd8);
    check("c6_state", 64'(DBG_STATE), 64'(ST_ISSUE));
    step();
    check("c7_valid", 64'(VALID_D), 64'd0);
    step();
    check("c8_instr", 64'(INSTR_D), 64'hC0DE_0008);

    // redirect while a 2-cycle response is still in flight
    mem_lat = 2;
    step();
    check("c9_state", 64'(DBG_STATE), 64'(ST_WAIT));
    PCSRC_M = 1'b1; PCBRANCH_M = 32'h0000_0043;
    #1;
    check("c9_req_flush", 64'(IMEM_REQ), 64'd0);
    step();
    PCSRC_M = 1'b0;
    check("c10_state", 64'(DBG_STATE), 64'(ST_DRAIN));
    check("c10_valid", 64'(VALID_D), 64'd0);
    check("c10_instr", 64'(INSTR_D), 64'd0);
    check("c10_addr",  64'(IMEM_ADDR), 64'h40);
    step();
    check("c11_req",  64'(IMEM_REQ), 64'd1);
    check("c11_addr", 64'(IMEM_ADDR), 64'h40);
    mem_lat = 1;
    step();
    step();
    check("c13_instr", 64'(INSTR_D), 64'hC0DE_0040);
    check("c13_pcp4",  64'(PCPLUS4_D), 64'h44);

    // flush and stall together: flush wins and squashes IF/ID
    PCSRC_M = 1'b1; STALL_D = 1'b1; PCBRANCH_M = 32'h0000_0080;
    #1;
    check("c13_req_flush", 64'(IMEM_REQ), 64'd0);
    step();
    PCSRC_M = 1'b0; STALL_D = 1'b0;
    check("c14_valid", 64'(VALID_D), 64'd0);
    check("c14_instr", 64'(INSTR_D), 64'd0);
    check("c14_addr",  64'(IMEM_ADDR), 64'h80);
    check("c14_state", 64'(DBG_STATE), 64'(ST_ISSUE));
    exp_q.push_back({32'hC0DE_0080, 32'h0000_0084});
    step();
    step();
    check("c16_instr", 64'(INSTR_D), 64'hC0DE_0080);

    // reset while holding a buffered word
    step();
    STALL_D = 1'b1;
    step();
    check("c18_state", 64'(DBG_STATE), 64'(ST_HOLD));
    RESET = 1'b0;
    step();
    check("hrst_valid", 64'(VALID_D), 64'd0);
    check("hrst_instr", 64'(INSTR_D), 64'd0);
    check("hrst_pcp4",  64'(PCPLUS4_D), 64'd0);
    check("hrst_addr",  64'(IMEM_ADDR), 64'd0);
    check("hrst_state", 64'(DBG_STATE), 64'(ST_ISSUE));
    check("hrst_req",   64'(IMEM_REQ), 64'd0);
    RESET = 1'b1; STALL_D = 1'b0;
    exp_q.push_back({32'h2002_0005, 32'h0000_0004});
    step();
    step();
    check("c21_instr", 64'(INSTR_D), 64'h2002_0005);
    step();
    RESET = 1'b0;
    step();

    // wrap-around instance
    check("w_rst_addr", 64'(addr2), 64'hFFFF_FFFC);
    check("w_rst_req",  64'(req2), 64'd0);
    RESET2 = 1'b1;
    #1;
    check("w_req", 64'(req2), 64'd1);
    step();
    check("w_state", 64'(st2), 64'(ST_WAIT));
    rvalid2 = 1'b1; rdata2 = 32'h1234_5678;
    step();
    rvalid2 = 1'b0;
    check("w_instr", 64'(instr2), 64'h1234_5678);
    check("w_pcp4",  64'(pcp4_2), 64'd0);
    check("w_valid", 64'(valid2), 64'd1);
    check("w_addr",  64'(addr2), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
